// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common-data-bus arbiter between ALU and memory-unit results
//
// Purpose: each source (ALU, MEM) owns a single-entry result buffer. Every
// cycle one held buffer is granted and its entry is registered onto the CDB
// at the next edge. A flush discards both buffers and any broadcast in flight.
//
// Optional feature: define CDB_ROUND_ROBIN_EN for round-robin arbitration on
// conflict; the default build uses fixed priority (MEM over ALU).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           misprediction recovery, drops pending results
//   alu_valid/tag/value, alu_ready  ALU result handshake
//   mem_valid/tag/value, mem_ready  memory-unit result handshake
//   cdb_valid/tag/value, cdb_src    registered broadcast (cdb_src: 0=ALU, 1=MEM)
module cdb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_DEPTH_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      alu_valid,
    input  logic [ROB_DEPTH_BITS-1:0] alu_tag,
    input  logic [DATA_WIDTH-1:0]     alu_value,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [ROB_DEPTH_BITS-1:0] mem_tag,
    input  logic [DATA_WIDTH-1:0]     mem_value,
    output logic                      mem_ready,
    output logic                      cdb_valid,
    output logic [ROB_DEPTH_BITS-1:0] cdb_tag,
    output logic [DATA_WIDTH-1:0]     cdb_value,
    output logic                      cdb_src
);

    logic                      alu_held;
    logic [ROB_DEPTH_BITS-1:0] alu_tag_q;
    logic [DATA_WIDTH-1:0]     alu_value_q;
    logic                      mem_held;
    logic [ROB_DEPTH_BITS-1:0] mem_tag_q;
    logic [DATA_WIDTH-1:0]     mem_value_q;
    logic                      grant_alu;
    logic                      grant_mem;

`ifdef CDB_ROUND_ROBIN_EN
    // Source granted most recently: 0 = ALU, 1 = MEM.
    logic last_grant;

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!flush) begin
            if (alu_held && mem_held) begin
                grant_alu = last_grant;
                grant_mem = !last_grant;
            end else begin
                grant_alu = alu_held;
                grant_mem = mem_held;
            end
        end
    end

    // Flush suppresses all grants, so the pointer stays put across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant_alu || grant_mem) begin
            last_grant <= grant_mem;
        end
    end
`else
    always_comb begin
        grant_mem = !flush && mem_held;
        grant_alu = !flush && alu_held && !mem_held;
    end
`endif

    // A buffer being drained this cycle can take a new result at the same
    // edge, which lets a sustained source stream one result per cycle.
    assign alu_ready = !flush && (!alu_held || grant_alu);
    assign mem_ready = !flush && (!mem_held || grant_mem);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_held    <= 1'b0;
            alu_tag_q   <= '0;
            alu_value_q <= '0;
            mem_held    <= 1'b0;
            mem_tag_q   <= '0;
            mem_value_q <= '0;
        end else if (flush) begin
            alu_held <= 1'b0;
            mem_held <= 1'b0;
        end else begin
            if (alu_valid && alu_ready) begin
                alu_held    <= 1'b1;
                alu_tag_q   <= alu_tag;
                alu_value_q <= alu_value;
            end else if (grant_alu) begin
                alu_held <= 1'b0;
            end
            if (mem_valid && mem_ready) begin
                mem_held    <= 1'b1;
                mem_tag_q   <= mem_tag;
                mem_value_q <= mem_value;
            end else if (grant_mem) begin
                mem_held <= 1'b0;
            end
        end
    end

    // Grants are already masked by flush, so a flush edge leaves cdb_valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= 1'b0;
        end else if (grant_alu || grant_mem) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= grant_mem ? mem_tag_q : alu_tag_q;
            cdb_value <= grant_mem ? mem_value_q : alu_value_q;
            cdb_src   <= grant_mem;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    localparam int DW = 32;
    localparam int RB = 1;
`ifdef CDB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RB-1:0] alu_tag = '0;
    logic [DW-1:0] alu_value = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [RB-1:0] mem_tag = '0;
    logic [DW-1:0] mem_value = '0;
    logic          mem_ready;
    logic          cdb_valid;
    logic [RB-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic          cdb_src;

    cdb_arbiter #(.DATA_WIDTH(DW), .ROB_DEPTH_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_tag(mem_tag), .mem_value(mem_value), .mem_ready(mem_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    // Model: per-source pending result (index 0=ALU, 1=MEM), arbitration
    // pointer, and the broadcast the bus must show.
    bit            held [2];
    logic [RB-1:0] ptag [2];
    logic [DW-1:0] pval [2];
    bit            acc  [2];
    int            m_last;
    bit            e_valid;
    logic [RB-1:0] e_tag;
    logic [DW-1:0] e_value;
    logic          e_src;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        held[0] = 0; held[1] = 0;
        acc[0] = 0; acc[1] = 0;
        m_last = 1;
        e_valid = 0; e_tag = '0; e_value = '0; e_src = 1'b0;
    endtask

    function automatic int pick();
        if (held[0] && held[1]) return RR ? (m_last == 1 ? 0 : 1) : 1;
        if (held[0]) return 0;
        if (held[1]) return 1;
        return -1;
    endfunction

    // Compare at the falling edge, then advance the model to the next rising edge.
    task automatic step();
        int  g;
        bit  r0, r1;
        @(negedge clk);
        g  = flush ? -1 : pick();
        r0 = !flush && (!held[0] || g == 0);
        r1 = !flush && (!held[1] || g == 1);
        cmp("alu_ready", alu_ready, r0);
        cmp("mem_ready", mem_ready, r1);
        cmp("cdb_valid", cdb_valid, e_valid);
        cmp("cdb_tag", cdb_tag, e_tag);
        cmp("cdb_value", cdb_value, e_value);
        cmp("cdb_src", cdb_src, e_src);
        acc[0] = 0; acc[1] = 0;
        if (flush) begin
            held[0] = 0; held[1] = 0;
            e_valid = 0;
        end else begin
            if (g >= 0) begin
                e_valid = 1; e_tag = ptag[g]; e_value = pval[g]; e_src = (g == 1);
                held[g] = 0;
                m_last = g;
            end else begin
                e_valid = 0;
            end
            if (alu_valid && r0) begin held[0] = 1; ptag[0] = alu_tag; pval[0] = alu_value; acc[0] = 1; end
            if (mem_valid && r1) begin held[1] = 1; ptag[1] = mem_tag; pval[1] = mem_value; acc[1] = 1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; flush = 0;
    endtask

    initial begin
        int mi, ai;
        model_reset();
        #12;
        cmp("rst_cdb_valid", cdb_valid, 0);
        cmp("rst_cdb_tag", cdb_tag, 0);
        cmp("rst_cdb_value", cdb_value, 0);
        cmp("rst_cdb_src", cdb_src, 0);
        @(posedge clk); #3 rst_n = 1; #1;
        cmp("rst_alu_ready", alu_ready, 1);
        cmp("rst_mem_ready", mem_ready, 1);

        // Conflict right after reset: round-robin favours ALU, fixed favours MEM.
        alu_valid = 1; alu_tag = 0; alu_value = 32'h11;
        mem_valid = 1; mem_tag = 1; mem_value = 32'h22;
        step(); idle(); step();
        cmp("conf_first_src", cdb_src, RR ? 0 : 1);
        cmp("conf_first_value", cdb_value, RR ? 32'h11 : 32'h22);
        step();
        cmp("conf_second_src", cdb_src, RR ? 1 : 0);
        cmp("conf_second_value", cdb_value, RR ? 32'h22 : 32'h11);
        step();
        cmp("conf_done_valid", cdb_valid, 0);

        // Single ALU result.
        alu_valid = 1; alu_tag = 1; alu_value = 32'hAA;
        step(); idle(); step();
        cmp("alu1_valid", cdb_valid, 1);
        cmp("alu1_tag", cdb_tag, 1);
        cmp("alu1_value", cdb_value, 32'hAA);
        cmp("alu1_src", cdb_src, 0);
        step();
        cmp("alu1_one_cycle", cdb_valid, 0);

        // Sustained MEM stream with two ALU results competing.
        mi = 0; ai = 0;
        for (int c = 0; c < 40 && (mi < 6 || ai < 2); c++) begin
            mem_valid = (mi < 6); mem_tag = mi[0]; mem_value = 32'h100 + mi;
            alu_valid = (ai < 2); alu_tag = (ai == 0) ? 1'b1 : 1'b0; alu_value = 32'hA1 + ai;
            #1;
`ifndef CDB_ROUND_ROBIN_EN
            if (ai == 1 && mi < 6 && c >= 1) cmp("alu_blocked_by_mem", alu_ready, 0);
`endif
            step();
            if (acc[1]) mi++;
            if (acc[0]) ai++;
        end
        cmp("stream_all_sent", mi + ai, 8);
        idle();
        repeat (4) step();

        // Back-to-back MEM results 1..4.
        for (int c = 0; c < 4; c++) begin
            mem_valid = 1; mem_tag = c[0]; mem_value = c + 1;
            #1;
            cmp("b2b_mem_ready", mem_ready, 1);
            step();
            if (c >= 1) cmp("b2b_value", cdb_value, c);
        end
        idle(); step();
        cmp("b2b_last_value", cdb_value, 4);
        cmp("b2b_last_valid", cdb_valid, 1);
        step();

        // Flush with both buffers held.
        alu_valid = 1; alu_tag = 1; alu_value = 32'h33;
        mem_valid = 1; mem_tag = 0; mem_value = 32'h44;
        step(); idle(); flush = 1; #1;
        cmp("flush_alu_ready", alu_ready, 0);
        cmp("flush_mem_ready", mem_ready, 0);
        step(); flush = 0;
        cmp("flush_cdb_valid", cdb_valid, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            cmp("flush_no_bcast", cdb_valid, 0);
        end

        // Asynchronous reset while broadcasting, with a MEM entry pending.
        alu_valid = 1; alu_tag = 0; alu_value = 32'h55;
        step();
        alu_valid = 0; mem_valid = 1; mem_tag = 1; mem_value = 32'h66;
        step(); idle();
        cmp("areset_pre_valid", cdb_valid, 1);
        #2 rst_n = 0; #1;
        cmp("areset_valid", cdb_valid, 0);
        cmp("areset_value", cdb_value, 0);
        cmp("areset_tag", cdb_tag, 0);
        model_reset();
        @(posedge clk); #2 rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            cmp("areset_no_bcast", cdb_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
